outbuf_drain_reader: RTL and testbench

- Reader end of the accelerator output buffer: pops 32-bit partial sums from the outbuf FIFO with the outbuf_ren / outbuf_empty / outbuf_dout handshake.
- Narrows each word to a 16-bit result and presents it on a valid/ready stream to the host side.
- One run per start pulse.
- Counts results and reports completion, replacing the bench-level polling loop with synthesizable logic next to design_top.

---
 rtl/outbuf_drain_reader_pkg.sv | 19 +
 rtl/outbuf_drain_reader_if.sv | 23 ++
 rtl/outbuf_drain_reader_result_skid_fifo.sv | 47 ++++
 rtl/outbuf_drain_reader.sv | 116 +++++++++++
 tb/tb_outbuf_drain_reader.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/outbuf_drain_reader_pkg.sv
// Shared types and constants for the outbuf drain reader: FSM encoding,
// saturation limits and skid buffer geometry.
package outbuf_drain_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [15:0] RES_MAX = 16'h7FFF;
    localparam logic [15:0] RES_MIN = 16'h8000;

    localparam int SKID_DEPTH = 2;
    localparam int SKID_PW    = $clog2(SKID_DEPTH);
    localparam int SKID_CW    = $clog2(SKID_DEPTH + 1);

endpackage

// File: rtl/outbuf_drain_reader_if.sv
// Outbuf FIFO read port plus the host-side result stream, bundled as one bus.
interface outbuf_drain_reader_if #(
    parameter int DATA_WIDTH = 32,
    parameter int RES_WIDTH  = 16
);
    logic                  outbuf_empty;
    logic                  outbuf_ren;
    logic [DATA_WIDTH-1:0] outbuf_dout;
    logic                  res_valid;
    logic                  res_ready;
    logic [RES_WIDTH-1:0]  res_data;
    logic                  res_last;

    // master = the drain reader, slave = FIFO + host environment
    modport master (
        input  outbuf_empty, outbuf_dout, res_ready,
        output outbuf_ren, res_valid, res_data, res_last
    );
    modport slave (
        output outbuf_empty, outbuf_dout, res_ready,
        input  outbuf_ren, res_valid, res_data, res_last
    );
endinterface

// File: rtl/outbuf_drain_reader_result_skid_fifo.sv
// Two-entry result FIFO between the outbuf read pipeline and the host stream;
// push and pop may happen in the same cycle.
module result_skid_fifo
    import outbuf_drain_reader_pkg::*;
#(
    parameter int W = 17
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [W-1:0]       push_data,
    input  logic               pop,
    output logic [W-1:0]       head,
    output logic [SKID_CW-1:0] count,
    output logic               empty
);
    logic [W-1:0]       mem [SKID_DEPTH];
    logic [SKID_PW-1:0] wr_ptr;
    logic [SKID_PW-1:0] rd_ptr;
    logic               full;
    logic               do_push;
    logic               do_pop;

    assign empty   = (count == '0);
    assign full    = (count == SKID_CW'(SKID_DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO can still accept a word when the head leaves the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SKID_DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + SKID_PW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + SKID_PW'(1);
            count <= count + SKID_CW'(do_push) - SKID_CW'(do_pop);
        end
    end

endmodule

// File: rtl/outbuf_drain_reader.sv
// Drains a fixed number of partial sums from the outbuf FIFO, narrows them to
// RES_WIDTH and streams them to the host, pulsing done at the end of a run.
module outbuf_drain_reader
    import outbuf_drain_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int RES_WIDTH  = 16,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] expected_cnt,
    input  logic                 sat_en,
    outbuf_drain_reader_if.master bus,
    output logic                 busy,
    output logic                 done,
    output logic                 sat_flag
);
    localparam int OW = SKID_CW + 1;

    state_e               state, state_nxt;
    logic [CNT_WIDTH-1:0] issued, delivered, expected;
    logic                 sat_en_q;
    logic                 inflight, inflight_last;

    logic                 start_ok, xfer, credit, ren;
    logic [OW-1:0]        occ;
    logic                 fits, clamp_hi, clamp_lo;
    logic [RES_WIDTH-1:0] narrowed;

    logic [RES_WIDTH:0]   head;
    logic [SKID_CW-1:0]   count;
    logic                 empty;

    // Pop credit counts the slot freed by a same-cycle host transfer, which
    // is what lets a steady stream run at one word per cycle.
    always_comb begin
        start_ok = (state == ST_IDLE) && start;
        xfer     = !empty && bus.res_ready;
        occ      = OW'(count) + OW'(inflight) - OW'(xfer);
        credit   = occ < OW'(SKID_DEPTH);
        ren      = (state == ST_DRAIN) && !bus.outbuf_empty &&
                   (issued < expected) && credit;
    end

    // The word fits when every bit from the result sign bit upward agrees.
    always_comb begin
        fits     = (&bus.outbuf_dout[DATA_WIDTH-1:RES_WIDTH-1]) ||
                   !(|bus.outbuf_dout[DATA_WIDTH-1:RES_WIDTH-1]);
        clamp_hi = sat_en_q && !fits && !bus.outbuf_dout[DATA_WIDTH-1];
        clamp_lo = sat_en_q && !fits &&  bus.outbuf_dout[DATA_WIDTH-1];
        narrowed = bus.outbuf_dout[RES_WIDTH-1:0];
        if (clamp_hi) narrowed = RES_MAX;
        if (clamp_lo) narrowed = RES_MIN;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = (expected_cnt == '0) ? ST_DONE : ST_DRAIN;
            ST_DRAIN: if (issued == expected) state_nxt = ST_FLUSH;
            ST_FLUSH: if (delivered + CNT_WIDTH'(xfer) == expected) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ST_IDLE;
            issued        <= '0;
            delivered     <= '0;
            expected      <= '0;
            sat_en_q      <= 1'b0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            sat_flag      <= 1'b0;
        end else begin
            state         <= state_nxt;
            inflight      <= ren;
            inflight_last <= ren && (issued == expected - CNT_WIDTH'(1));
            if (start_ok) begin
                issued    <= '0;
                delivered <= '0;
                expected  <= expected_cnt;
                sat_en_q  <= sat_en;
                sat_flag  <= 1'b0;
            end else begin
                if (ren)  issued    <= issued + CNT_WIDTH'(1);
                if (xfer) delivered <= delivered + CNT_WIDTH'(1);
                if (inflight && (clamp_hi || clamp_lo)) sat_flag <= 1'b1;
            end
        end
    end

    // outbuf_dout is valid the cycle after the pop, i.e. while inflight is set.
    result_skid_fifo #(.W(RES_WIDTH + 1)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_data ({inflight_last, narrowed}),
        .pop       (xfer),
        .head      (head),
        .count     (count),
        .empty     (empty)
    );

    assign bus.outbuf_ren = ren;
    assign bus.res_valid  = !empty;
    assign bus.res_data   = head[RES_WIDTH-1:0];
    assign bus.res_last   = !empty && head[RES_WIDTH];
    assign busy           = (state == ST_DRAIN) || (state == ST_FLUSH);
    assign done           = (state == ST_DONE);

endmodule

// File: tb/tb_outbuf_drain_reader.sv
// Bench for outbuf_drain_reader: FIFO/host environment model, table vectors,
// hand-written corner sequences and randomized runs against a narrowing model.
module tb_outbuf_drain_reader;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] expected_cnt = 8'd0;
    logic       sat_en = 1'b0;
    logic       busy, done, sat_flag;

    outbuf_drain_reader_if #(.DATA_WIDTH(32), .RES_WIDTH(16)) bus ();

    outbuf_drain_reader dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .expected_cnt (expected_cnt),
        .sat_en       (sat_en),
        .bus          (bus),
        .busy         (busy),
        .done         (done),
        .sat_flag     (sat_flag)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // outbuf FIFO model: circular store, popped one cycle after ren
    logic [31:0] mem [256];
    int          rd = 0, wr = 0;
    logic [31:0] feed_q [$];
    int          feed_gap = 0;
    bit          ren_s = 0;
    int          rdy_mode = 0;  // 0 ready high, 1 random, 2 ready low
    assign bus.outbuf_empty = (rd == wr);

    logic [16:0] exp_q [$];   // {last, data} in delivery order
    logic [31:0] wbuf [16];
    int          cyc = 0;
    int          run_ren, run_xfer, first_ren, first_valid, first_xfer, last_xfer;
    bit          hold_prev = 0;
    logic [15:0] prev_data;
    logic [16:0] mon_e;

    typedef struct packed {
        logic [7:0]        n;
        logic              sat;
        logic [3:0][31:0]  w;
        logic [3:0][15:0]  e;
        logic              flag;
    } vec_t;
    vec_t vt [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [16:0] model_res(input logic [31:0] w, input bit sat,
                                              input bit last, output bit clamped);
        int v;
        v = $signed(w);
        clamped = 0;
        if (sat && v > 32767)  begin clamped = 1; return {last, 16'h7FFF}; end
        if (sat && v < -32768) begin clamped = 1; return {last, 16'h8000}; end
        return {last, w[15:0]};
    endfunction

    // Monitor: samples mid-cycle, when all inputs of the cycle are settled.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            if (bus.outbuf_ren) begin
                chk("ren_while_empty", bus.outbuf_empty, 0);
                run_ren++;
                if (first_ren < 0) first_ren = cyc;
            end
            ren_s = bus.outbuf_ren;
            if (bus.res_valid && first_valid < 0) first_valid = cyc;
            if (hold_prev) begin
                chk("hold_valid", bus.res_valid, 1);
                chk("hold_data", bus.res_data, prev_data);
            end
            if (bus.res_valid && bus.res_ready) begin
                run_xfer++;
                if (first_xfer < 0) first_xfer = cyc;
                last_xfer = cyc;
                chk("result_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    chk("res_data", bus.res_data, mon_e[15:0]);
                    chk("res_last", bus.res_last, mon_e[16]);
                end
            end
            if (bus.outbuf_ren) chk("popped_not_delivered_le2", (run_ren - run_xfer) <= 2, 1);
            hold_prev = bus.res_valid && !bus.res_ready;
            prev_data = bus.res_data;
            if (done && last_xfer >= 0) chk("done_after_last", cyc - last_xfer, 1);
        end else begin
            hold_prev = 0;
            ren_s     = 0;
        end
    end

    // Environment driver: FIFO pop/refill and host ready, just after the edge.
    always @(posedge clk) begin
        #1;
        if (ren_s) begin
            bus.outbuf_dout = mem[rd % 256];
            rd++;
        end
        if (feed_q.size() > 0 && feed_gap > 0 && (cyc % feed_gap) == 0) begin
            mem[wr % 256] = feed_q.pop_front();
            wr++;
        end
        case (rdy_mode)
            0:       bus.res_ready = 1'b1;
            1:       bus.res_ready = 1'($urandom_range(0, 1));
            default: bus.res_ready = 1'b0;
        endcase
    end

    task automatic set_vec(input int i, input int n, input bit sat,
                           input logic [31:0] w0, w1, w2, w3,
                           input logic [15:0] e0, e1, e2, e3, input bit flag);
        vt[i].n = 8'(n); vt[i].sat = sat; vt[i].flag = flag;
        vt[i].w = {w3, w2, w1, w0};
        vt[i].e = {e3, e2, e1, e0};
    endtask

    // Expected results from the model for wbuf[0..n-1]; returns clamp summary.
    task automatic model_fill(input int n, input bit sat, output bit any_clamp);
        bit c;
        any_clamp = 0;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(model_res(wbuf[i], sat, i == n - 1, c));
            any_clamp |= c;
        end
    endtask

    task automatic begin_run(input int n, input bit sat, input int gap);
        run_ren = 0; run_xfer = 0;
        first_ren = -1; first_valid = -1; first_xfer = -1; last_xfer = -1;
        feed_gap = gap;
        for (int i = 0; i < n; i++) begin
            if (gap == 0) begin mem[wr % 256] = wbuf[i]; wr++; end
            else feed_q.push_back(wbuf[i]);
        end
        start = 1'b1; expected_cnt = 8'(n); sat_en = sat;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, input int inj, input bit busy_chk, output int kd);
        kd = -1;
        for (int k = 0; k < max_cyc; k++) begin
            if (done) begin kd = k; break; end
            if (busy_chk) chk("busy_during_run", busy, 1);
            if (k == inj) begin
                chk("busy_at_ignored_start", busy, 1);
                start = 1'b1; expected_cnt = 8'd7; sat_en = ~sat_en;
            end else start = 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
        chk("done_seen", kd >= 0, 1);
    endtask

    task automatic full_run(input int n, input bit sat, input int gap, input bit exp_flag,
                            input bit consec, input bit busy_chk, input int inj, output int kd);
        begin_run(n, sat, gap);
        wait_done(400, inj, busy_chk, kd);
        chk("all_delivered", exp_q.size(), 0);
        chk("sat_flag", sat_flag, exp_flag);
        chk("delivered_count", run_xfer, n);
        if (n > 0) chk("first_valid_latency", first_valid - first_ren, 2);
        if (consec) chk("back_to_back", last_xfer - first_xfer, n - 1);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("idle_not_busy", busy, 0);
    endtask

    initial begin
        int  kd;
        bit  flag;
        int  n;
        bit  sat;

        bus.res_ready   = 1'b1;
        bus.outbuf_dout = 32'd0;
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ren", bus.outbuf_ren, 0);
        chk("rst_valid", bus.res_valid, 0);
        chk("rst_last", bus.res_last, 0);
        chk("rst_data", bus.res_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sat_flag", sat_flag, 0);
        rst = 1'b1;
        @(negedge clk);

        // Table vectors: basic drain, saturation on/off, clamp boundaries
        set_vec(0, 3, 1, 32'h1, 32'h2, 32'hFFFF_FFFE, 32'h0,
                16'h0001, 16'h0002, 16'hFFFE, 16'h0, 0);
        set_vec(1, 2, 1, 32'h0001_0000, 32'hFFFF_0000, 32'h0, 32'h0,
                16'h7FFF, 16'h8000, 16'h0, 16'h0, 1);
        set_vec(2, 2, 0, 32'h0001_0000, 32'hFFFF_0000, 32'h0, 32'h0,
                16'h0000, 16'h0000, 16'h0, 16'h0, 0);
        set_vec(3, 4, 1, 32'h0000_7FFF, 32'hFFFF_8000, 32'h0000_8000, 32'hFFFF_7FFF,
                16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 1);
        rdy_mode = 0;
        for (int v = 0; v < 4; v++) begin
            for (int i = 0; i < int'(vt[v].n); i++) begin
                wbuf[i] = vt[v].w[i];
                exp_q.push_back({i == int'(vt[v].n) - 1, vt[v].e[i]});
            end
            full_run(int'(vt[v].n), vt[v].sat, 0, vt[v].flag, 1, 0, -1, kd);
        end

        // Backpressure: ready low for 5 cycles at the start of a 4-word run
        wbuf[0] = 32'h11; wbuf[1] = 32'h22; wbuf[2] = 32'h33; wbuf[3] = 32'h44;
        model_fill(4, 0, flag);
        rdy_mode = 2;
        begin_run(4, 0, 0);
        repeat (5) @(negedge clk);
        chk("bp_pops_before_stall", run_ren, 2);
        chk("bp_no_transfer", run_xfer, 0);
        rdy_mode = 0;
        wait_done(100, -1, 0, kd);
        chk("bp_all_delivered", exp_q.size(), 0);
        chk("bp_delivered_count", run_xfer, 4);
        @(negedge clk);

        // Empty gaps: one word every 3 cycles, busy must stay high
        wbuf[0] = 32'd5; wbuf[1] = 32'hFFFF_FFFB; wbuf[2] = 32'h0000_7FFF; wbuf[3] = 32'h0001_2345;
        model_fill(4, 1, flag);
        full_run(4, 1, 3, flag, 0, 1, -1, kd);

        // Zero-length run: done next cycle, no pops
        full_run(0, 0, 0, 0, 0, 0, -1, kd);
        chk("zero_done_next_cycle", kd, 0);
        chk("zero_no_ren", run_ren, 0);

        // Start pulse during DRAIN is ignored
        wbuf[0] = 32'hA1; wbuf[1] = 32'hFFFF_0000; wbuf[2] = 32'hA3; wbuf[3] = 32'hA4;
        model_fill(4, 0, flag);
        full_run(4, 0, 2, flag, 0, 0, 2, kd);

        // Asynchronous reset mid-run after two results
        wbuf[0] = 32'h0010_0000; wbuf[1] = 32'h2; wbuf[2] = 32'h3; wbuf[3] = 32'h4;
        model_fill(4, 1, flag);
        rdy_mode = 0;
        begin_run(4, 1, 0);
        for (int k = 0; k < 40; k++) begin
            #1;
            if (run_xfer >= 2) break;
            @(negedge clk);
        end
        chk("rst_two_delivered", run_xfer, 2);
        chk("rst_flag_before", sat_flag, 1);
        #1 rst = 1'b0; ren_s = 0;
        #1;
        chk("arst_ren", bus.outbuf_ren, 0);
        chk("arst_valid", bus.res_valid, 0);
        chk("arst_last", bus.res_last, 0);
        chk("arst_data", bus.res_data, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_sat_flag", sat_flag, 0);
        exp_q.delete(); feed_q.delete(); rd = wr;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        wbuf[0] = 32'hFFFF_FFF0; wbuf[1] = 32'h0000_1234;
        model_fill(2, 1, flag);
        full_run(2, 1, 0, flag, 1, 0, -1, kd);

        // Randomized runs: random data, gaps and host backpressure
        rdy_mode = 1;
        for (int r = 0; r < 25; r++) begin
            n   = $urandom_range(1, 12);
            sat = 1'($urandom_range(0, 1));
            for (int i = 0; i < n; i++) begin
                case ($urandom_range(0, 2))
                    0:       wbuf[i] = $urandom;
                    1:       wbuf[i] = 32'(int'($urandom_range(0, 80000)) - 40000);
                    default: wbuf[i] = {{16{1'($urandom_range(0, 1))}}, 16'($urandom)};
                endcase
            end
            model_fill(n, sat, flag);
            full_run(n, sat, $urandom_range(0, 3), flag, 0, 0, -1, kd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
